// File: rtl/square_scheduler_pkg.sv
// ============================================================================
//  Module   : square_pkg
//  Purpose  : Shared constants, widths and FSM state type for square_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package square_pkg;

    localparam int COLOR_W = 30;
    localparam int COORD_W = 10;

    localparam logic [COORD_W-1:0] VIS_W = 10'd640;
    localparam logic [COORD_W-1:0] VIS_H = 10'd480;
    localparam logic [COLOR_W-1:0] WHITE = 30'h3FFF_FFFF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EVAL   = 2'd1;
    localparam logic [1:0] ST_STEP_A = 2'd2;
    localparam logic [1:0] ST_STEP_B = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_EVAL   = ST_EVAL,
        S_STEP_A = ST_STEP_A,
        S_STEP_B = ST_STEP_B
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/square_scheduler_if.sv
// ============================================================================
//  Module   : square_scheduler_if
//  Purpose  : Pixel/colour inputs and step/colour outputs of the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface square_scheduler_if;
    import square_pkg::*;

    logic [COORD_W-1:0] cur_width;
    logic [COORD_W-1:0] cur_height;
    logic [COLOR_W-1:0] color_a;
    logic [COLOR_W-1:0] color_b;
    logic               pause;
    logic               next_a;
    logic               next_b;
    logic [COLOR_W-1:0] outcolor;
    logic               top_is_b;
    logic               collision;
    logic [15:0]        frame_cnt;

    modport master (
        output cur_width, cur_height, color_a, color_b, pause,
        input  next_a, next_b, outcolor, top_is_b, collision, frame_cnt
    );

    modport slave (
        input  cur_width, cur_height, color_a, color_b, pause,
        output next_a, next_b, outcolor, top_is_b, collision, frame_cnt
    );

endinterface

`default_nettype wire

// File: rtl/square_scheduler_frame_divider.sv
// ============================================================================
//  Module   : frame_divider
//  Purpose  : 8-bit frame divider raising a sticky step request every period.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_divider (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    input  wire logic       i_clr,
    input  wire logic [7:0] i_period,
    output logic            o_req
);
    logic [7:0] r_cnt;
    logic       r_req;
    logic       w_hit;

    assign w_hit = i_en && (r_cnt == (i_period - 8'd1));
    assign o_req = r_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_req <= 1'b0;
        end else begin
            if (i_en) begin
                r_cnt <= w_hit ? 8'd0 : r_cnt + 8'd1;
            end
            if (i_clr) begin
                r_req <= 1'b0;
            end else if (w_hit) begin
                r_req <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/square_scheduler.sv
// ============================================================================
//  Module   : square_scheduler
//  Purpose  : Frame tick, staggered step strobes, collision freeze and
//             priority compositing for two squares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_scheduler #(
    parameter logic [square_pkg::COORD_W-1:0] VIS_W         = square_pkg::VIS_W,
    parameter logic [square_pkg::COORD_W-1:0] VIS_H         = square_pkg::VIS_H,
    parameter int                             PERIOD_A      = 1,
    parameter int                             PERIOD_B      = 2,
    parameter int                             FREEZE_FRAMES = 30,
    parameter logic [square_pkg::COLOR_W-1:0] WHITE         = square_pkg::WHITE
) (
    input  wire logic         clk,
    input  wire logic         rst,
    square_scheduler_if.slave bus
);
    import square_pkg::*;

    localparam logic [7:0] c_period_a = 8'(PERIOD_A);
    localparam logic [7:0] c_period_b = 8'(PERIOD_B);
    localparam logic [7:0] c_freeze   = 8'(FREEZE_FRAMES);

    sched_state_t       r_state;
    logic               r_frame_d;
    logic               r_overlap_seen;
    logic               r_overlap_frame;
    logic               r_collision;
    logic               r_top_is_b;
    logic [7:0]         r_freeze_cnt;
    logic [15:0]        r_frame_cnt;
    logic [COLOR_W-1:0] r_outcolor;

    logic               w_frame_cond;
    logic               w_tick;
    logic               w_visible;
    logic               w_overlap_px;
    logic               w_div_en;
    logic               w_div_clr;
    logic               w_req_a;
    logic               w_req_b;
    logic [COLOR_W-1:0] w_top_color;
    logic [COLOR_W-1:0] w_other_color;

    assign w_frame_cond  = (bus.cur_width == '0) && (bus.cur_height == VIS_H);
    assign w_tick        = w_frame_cond && !r_frame_d;
    assign w_visible     = (bus.cur_width < VIS_W) && (bus.cur_height < VIS_H);
    assign w_overlap_px  = w_visible && (bus.color_a != WHITE) && (bus.color_b != WHITE);
    // Dividers only advance on an EVAL that is neither starting nor serving a freeze.
    assign w_div_en      = (r_state == S_EVAL) && (r_freeze_cnt == 8'd0) &&
                           !r_overlap_frame && !bus.pause;
    assign w_div_clr     = (r_state == S_STEP_B);
    assign w_top_color   = r_top_is_b ? bus.color_b : bus.color_a;
    assign w_other_color = r_top_is_b ? bus.color_a : bus.color_b;

    frame_divider u_div_a (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_div_en),
        .i_clr    (w_div_clr),
        .i_period (c_period_a),
        .o_req    (w_req_a)
    );

    frame_divider u_div_b (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_div_en),
        .i_clr    (w_div_clr),
        .i_period (c_period_b),
        .o_req    (w_req_b)
    );

    // Strobes are decoded from registered state and requests; rst kills a pending one at once.
    assign bus.next_a    = (r_state == S_STEP_A) && w_req_a && !rst;
    assign bus.next_b    = (r_state == S_STEP_B) && w_req_b && !rst;
    assign bus.outcolor  = r_outcolor;
    assign bus.top_is_b  = r_top_is_b;
    assign bus.collision = r_collision;
    assign bus.frame_cnt = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_frame_d       <= 1'b0;
            r_overlap_seen  <= 1'b0;
            r_overlap_frame <= 1'b0;
            r_collision     <= 1'b0;
            r_top_is_b      <= 1'b0;
            r_freeze_cnt    <= 8'd0;
            r_frame_cnt     <= 16'd0;
        end else begin
            r_frame_d <= w_frame_cond;
            if (w_tick) begin
                r_overlap_seen <= 1'b0;
            end else if (w_overlap_px) begin
                r_overlap_seen <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_overlap_frame <= r_overlap_seen;
                        r_frame_cnt     <= r_frame_cnt + 16'd1;
                        r_state         <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_overlap_frame && (r_freeze_cnt == 8'd0)) begin
                        r_freeze_cnt <= c_freeze;
                        r_collision  <= 1'b1;
                        r_top_is_b   <= !r_top_is_b;
                    end else if (r_freeze_cnt != 8'd0) begin
                        r_freeze_cnt <= r_freeze_cnt - 8'd1;
                        if (r_freeze_cnt == 8'd1) begin
                            r_collision <= 1'b0;
                        end
                    end
                    r_state <= S_STEP_A;
                end
                S_STEP_A: r_state <= S_STEP_B;
                S_STEP_B: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outcolor <= WHITE;
        end else if (!w_visible) begin
            r_outcolor <= WHITE;
        end else if (w_top_color != WHITE) begin
            r_outcolor <= w_top_color;
        end else if (w_other_color != WHITE) begin
            r_outcolor <= w_other_color;
        end else begin
            r_outcolor <= WHITE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_square_scheduler.sv
// ============================================================================
//  Module   : tb_square_scheduler
//  Purpose  : Self-checking bench for square_scheduler with a strobe scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_scheduler;

    localparam int          PA    = 1;
    localparam int          PB    = 2;
    localparam int          FRZ   = 30;
    localparam logic [29:0] W     = 30'h3FFF_FFFF;
    localparam logic [29:0] BLUE  = 30'h0000_03FF;
    localparam logic [29:0] RED   = 30'h3FF0_0000;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    int   qa[$];
    int   qb[$];

    // Reference model state
    int          m_da, m_db, m_frz;
    bit          m_col, m_top, m_ovl;
    logic [15:0] m_frame;

    square_scheduler_if bus_if ();

    square_scheduler #(
        .PERIOD_A      (PA),
        .PERIOD_B      (PB),
        .FREEZE_FRAMES (FRZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Strobe scoreboard: every strobe observed must match a queued expectation and vice versa.
    always @(negedge clk) begin : mon
        bit ea, eb;
        ea = (qa.size() > 0) && (qa[0] == cyc);
        eb = (qb.size() > 0) && (qb[0] == cyc);
        if (ea) void'(qa.pop_front());
        if (eb) void'(qb.pop_front());
        if (ea || bus_if.next_a) check_val("next_a", {31'd0, bus_if.next_a}, {31'd0, ea});
        if (eb || bus_if.next_b) check_val("next_b", {31'd0, bus_if.next_b}, {31'd0, eb});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [29:0] exp_color(input int w, input int h,
                                              input logic [29:0] ca, input logic [29:0] cb);
        logic [29:0] t, o;
        if (!(w < 640 && h < 480)) return W;
        t = m_top ? cb : ca;
        o = m_top ? ca : cb;
        if (t != W) return t;
        if (o != W) return o;
        return W;
    endfunction

    task automatic drive_px(input int w, input int h, input logic [29:0] ca, input logic [29:0] cb);
        bus_if.cur_width  = 10'(w);
        bus_if.cur_height = 10'(h);
        bus_if.color_a    = ca;
        bus_if.color_b    = cb;
        if (w < 640 && h < 480 && ca != W && cb != W) m_ovl = 1'b1;
    endtask

    task automatic model_reset();
        m_da = 0; m_db = 0; m_frz = 0;
        m_col = 0; m_top = 0; m_ovl = 0;
        m_frame = 16'd0;
        qa.delete();
        qb.delete();
    endtask

    task automatic model_tick(input int n, input bit p);
        bit of, ra, rb;
        ra = 0; rb = 0;
        m_frame = m_frame + 16'd1;
        of = m_ovl;
        m_ovl = 0;
        if (of && m_frz == 0) begin
            m_frz = FRZ; m_col = 1; m_top = !m_top;
        end else if (m_frz > 0) begin
            m_frz--;
            if (m_frz == 0) m_col = 0;
        end else if (!p) begin
            if (m_da == PA - 1) begin m_da = 0; ra = 1; end else m_da++;
            if (m_db == PB - 1) begin m_db = 0; rb = 1; end else m_db++;
        end
        if (ra) qa.push_back(n + 2);
        if (rb) qb.push_back(n + 3);
    endtask

    task automatic comp_test(input string tag, input int w, input int h,
                             input logic [29:0] ca, input logic [29:0] cb,
                             input logic [29:0] req);
        drive_px(w, h, ca, cb);
        step();
        check_val(tag, {2'b0, bus_if.outcolor}, {2'b0, req});
        check_val({tag, "_model"}, {2'b0, bus_if.outcolor}, {2'b0, exp_color(w, h, ca, cb)});
        drive_px(1, 480, W, W);
    endtask

    task automatic frame(input bit ovl, input bit p, input int hold, input bit dbl);
        int          n;
        logic [29:0] e;
        bus_if.pause = p;
        step();
        if (ovl) begin
            e = exp_color(250, 250, BLUE, RED);
            drive_px(250, 250, BLUE, RED);
        end else begin
            e = exp_color(300, 200, BLUE, W);
            drive_px(300, 200, BLUE, W);
        end
        step();
        check_val(ovl ? "comp_ovl" : "comp_a", {2'b0, bus_if.outcolor}, {2'b0, e});
        drive_px(10, 20, W, W);
        step();
        drive_px(0, 480, W, W);
        n = cyc;
        model_tick(n, p);
        repeat (hold - 1) step();
        if (dbl) begin
            step(); drive_px(5, 480, W, W);
            step(); drive_px(0, 480, W, W);
        end
        step();
        drive_px(1, 480, W, W);
        repeat (5) step();
        check_val("frame_cnt", {16'd0, bus_if.frame_cnt}, {16'd0, m_frame});
        check_val("collision", {31'd0, bus_if.collision}, {31'd0, m_col});
        check_val("top_is_b", {31'd0, bus_if.top_is_b}, {31'd0, m_top});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_frame_cnt"}, {16'd0, bus_if.frame_cnt}, 32'd0);
        check_val({tag, "_collision"}, {31'd0, bus_if.collision}, 32'd0);
        check_val({tag, "_top_is_b"}, {31'd0, bus_if.top_is_b}, 32'd0);
        check_val({tag, "_outcolor"}, {2'b0, bus_if.outcolor}, {2'b0, W});
        check_val({tag, "_next_a"}, {31'd0, bus_if.next_a}, 32'd0);
        check_val({tag, "_next_b"}, {31'd0, bus_if.next_b}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int n;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst = 1'b1;
        bus_if.pause = 1'b0;
        drive_px(1, 480, W, W);
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Compositor without any overlap (top_is_b = 0)
        comp_test("comp_only_b", 300, 200, W, RED, RED);
        comp_test("comp_only_a", 300, 200, BLUE, W, BLUE);
        comp_test("comp_white", 300, 200, W, W, W);
        comp_test("comp_offscreen", 700, 10, BLUE, RED, W);
        comp_test("comp_blank_line", 10, 480, BLUE, RED, W);

        // Three plain frames: A every frame, B every second frame
        repeat (3) frame(0, 0, 1, 0);
        check_val("frame_cnt_3", {16'd0, bus_if.frame_cnt}, 32'd3);

        // Pixel counter parked on the tick position for 5 cycles
        frame(0, 0, 5, 0);
        // Second frame_cond edge while the FSM is busy
        frame(0, 0, 1, 1);

        // Pause for 4 frames, then resume with the same divider phase
        repeat (4) frame(0, 1, 1, 0);
        repeat (3) frame(0, 0, 1, 0);

        // Collision: overlap with A on top, then freeze
        frame(1, 0, 1, 0);
        check_val("collision_set", {31'd0, bus_if.collision}, 32'd1);
        check_val("top_toggled", {31'd0, bus_if.top_is_b}, 32'd1);
        for (int i = 1; i <= FRZ; i++) begin
            frame(i == 5, 0, 1, 0);
            if (i == FRZ - 1) check_val("freeze_29", {31'd0, bus_if.collision}, 32'd1);
        end
        check_val("freeze_done", {31'd0, bus_if.collision}, 32'd0);
        repeat (3) frame(0, 0, 1, 0);

        // Reset asserted while in STEP_A
        step();
        drive_px(0, 480, W, W);
        n = cyc;
        step();
        drive_px(1, 480, W, W);
        step();
        rst = 1'b1;
        #1;
        check_val("rst_step_a_next_a", {31'd0, bus_if.next_a}, 32'd0);
        step();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        model_reset();
        step();
        check_val("rst_after_next_a", {31'd0, bus_if.next_a}, 32'd0);
        repeat (2) frame(0, 0, 1, 0);

        repeat (6) step();
        check_val("qa_drained", qa.size(), 32'd0);
        check_val("qb_drained", qb.size(), 32'd0);
        if (n < 0) check_val("n_sanity", n, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/square_scheduler.md
Name: square_scheduler

Overview:
- Frame-level controller and compositor for two bouncing squares: `square_a` (auto-bouncing) and `square_b` (keyboard-driven).
- Derives a frame tick from the VGA pixel counters and issues each square's one-cycle `next` step strobe at a per-square frame rate.
- Detects pixel overlap between the squares and arbitrates which square is drawn on top.
- Sits between the square instances and the VGA output stage; replaces the ad-hoc `next` wiring and colour muxing.

Parameters:
- VIS_W, 640, visible width; pixel counter range 0..VIS_W-1
- VIS_H, 480, visible height; first blank line is `cur_height == VIS_H`
- PERIOD_A, 1, frames per step of square A (1..255)
- PERIOD_B, 2, frames per step of square B (1..255)
- FREEZE_FRAMES, 30, frames both squares are held after a collision (1..255)
- WHITE, 30'h3FFFFFFF, background colour; a square input equal to WHITE means "not covered"

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cur_width  in  10  current pixel x from VGA timing
- cur_height  in  10  current pixel y from VGA timing
- color_a  in  30  square A colour output for the current pixel
- color_b  in  30  square B colour output for the current pixel
- pause  in  1  level; while high, no steps are issued and dividers hold
- next_a  out  1  one-cycle step strobe to square A
- next_b  out  1  one-cycle step strobe to square B
- outcolor  out  30  composited pixel colour (registered)
- top_is_b  out  1  1 = square B has draw priority
- collision  out  1  high while a freeze is in progress
- frame_cnt  out  16  free-running frame counter, wraps at 65535 to 0

Behaviour:
- Reset:
  - Applied synchronously; applies when `rst` is high at a clk edge.
  - Every output and internal register is cleared: `next_a/b`=0, `outcolor`=WHITE, `top_is_b`=0, `collision`=0, `frame_cnt`=0, dividers=0, `freeze_cnt`=0, `overlap_seen`=0, `frame_d`=0, FSM=IDLE.
  - Reset mid-sequence aborts any pending strobe; no strobe is emitted in the reset cycle or the cycle after.
- Frame tick:
  - `frame_cond` = (`cur_width`==0 && `cur_height`==VIS_H).
  - Register it as `frame_d`; `tick` = `frame_cond` & ~`frame_d`.
  - This gives exactly one tick per frame regardless of how many clk cycles the pixel counter holds a value.
- Overlap: in visible area (`cur_width`<VIS_W, `cur_height`<VIS_H), if `color_a`!=WHITE and `color_b`!=WHITE, set `overlap_seen`. It is cleared on tick, after being sampled.
- FSM states: IDLE, EVAL, STEP_A, STEP_B.
  - IDLE: on tick → EVAL; `frame_cnt`++.
  - EVAL (1 cycle), first matching case applies:
    - (a) If `overlap_seen` and `freeze_cnt`==0: `freeze_cnt` ← FREEZE_FRAMES, `collision` ← 1, toggle `top_is_b`.
    - (b) Else if `freeze_cnt`>0: decrement; when it reaches 0, `collision` ← 0.
    - (c) Else if !`pause`: `div_a`++ and `div_b`++; a divider reaching PERIOD-1 sets its step-request flag and reloads to 0.
    - Then → STEP_A.
  - STEP_A: `next_a` = request_a for exactly this cycle → STEP_B.
  - STEP_B: `next_b` = request_b for exactly this cycle; clear requests → IDLE.
  - Strobes are therefore staggered: `next_a` at tick+2 cycles, `next_b` at tick+3. They are never simultaneous.
- Tick during a non-IDLE state: ignored. This cannot occur in a legal VGA frame; the bench must check that no double step results.
- `pause` during a freeze: the freeze still counts down; dividers are untouched.
- Compositor, 1-cycle latency, registered:
  - If the top square's colour != WHITE, output it.
  - Else if the other square's colour != WHITE, output it.
  - Else output WHITE.
  - Outside the visible area the output is WHITE.
- Widths: divider and freeze counters are 8 bits. `frame_cnt` is 16 bits and wraps silently.

Decomposition:
- Shared package `square_pkg`:
  - Constants VIS_W, VIS_H, WHITE.
  - Colour width 30 and coordinate width 10.
  - FSM state enum `sched_state_t`.
- One natural sub-module, `frame_divider`: 8-bit counter with period, enable and reload, emitting a request flag. It is instantiated twice, once for A and once for B.
- The compositor stays inline.

Test Plan:
- Reset, then run 3 frames at PERIOD_A=1, PERIOD_B=2, no overlap → `next_a` pulses once per frame at tick+2; `next_b` pulses in frames 2 only (every 2nd), at tick+3; `frame_cnt`=3.
- Hold the pixel counter at (0,480) for 5 clk cycles → exactly one tick, one EVAL, and one `frame_cnt` increment.
- Drive `color_a`=blue and `color_b`=red at pixel (250,250) in frame 1 → at the following EVAL `collision`=1 and `top_is_b`=1; no strobes for 30 frames; `collision`=0 at the 30th frame's EVAL; stepping resumes the frame after.
- Overlapping pixel with `top_is_b`=0 → `outcolor`=blue one cycle later. Only `color_b` non-white → red. Both WHITE → WHITE. Pixel (700,10) → WHITE.
- Assert `pause` for 4 frames → no `next_a`/`next_b`, dividers frozen; releasing `pause` resumes the same divider phase.
- Assert `rst` in the STEP_A cycle → `next_a`=0 that cycle; all outputs at reset values next cycle; FSM is IDLE.
